// File: rtl/irq_prio_ctrl.sv
// Registered interrupt priority controller: latches edge/level requests, masks them,
// picks one source by fixed or round-robin priority and runs a req/ack/eoi handshake.
module irq_prio_ctrl #(
    parameter int unsigned N           = 32,
    parameter int unsigned IDX_W       = 5,
    parameter int unsigned ROUND_ROBIN = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     irq_in,
    input  logic [N-1:0]     edge_mode,
    input  logic [N-1:0]     mask,
    input  logic             ack,
    input  logic             eoi,
    output logic             irq_req,
    output logic [IDX_W-1:0] irq_id,
    output logic             in_service,
    output logic [N-1:0]     pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [N-1:0]     irq_in_q;
    logic [N-1:0]     pending_d;
    logic [N-1:0]     edge_set_c;
    logic [N-1:0]     eligible_c;
    logic [N-1:0]     clr_c;
    logic [N-1:0]     rot_c;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [IDX_W-1:0] irq_id_d;
    logic [IDX_W-1:0] sel_idx_c;
    logic             sel_valid_c;
    logic             cur_eligible_c;
    logic             irq_req_d;
    logic             in_service_d;
    int unsigned      base_c;

    assign edge_set_c     = irq_in & ~irq_in_q;
    assign eligible_c     = pending & ~mask;
    assign cur_eligible_c = |(eligible_c & (N'(1) << irq_id));

    // Rotate eligible so that bit 0 is the search start, then find first one.
    always_comb begin
        base_c      = (ROUND_ROBIN != 0) ? 32'(rr_ptr) : 32'd0;
        rot_c       = (eligible_c >> base_c) | (eligible_c << (N - base_c));
        sel_idx_c   = '0;
        sel_valid_c = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!sel_valid_c && rot_c[k]) begin
                sel_valid_c = 1'b1;
                sel_idx_c   = IDX_W'((base_c + k) % N);
            end
        end
    end

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_d      = state;
        irq_req_d    = irq_req;
        irq_id_d     = irq_id;
        in_service_d = in_service;
        rr_ptr_d     = rr_ptr;
        clr_c        = '0;
        case (state)
            IDLE: begin
                if (sel_valid_c) begin
                    irq_id_d  = sel_idx_c;
                    irq_req_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    irq_req_d    = 1'b0;
                    in_service_d = 1'b1;
                    clr_c        = (N'(1) << irq_id) & edge_mode;
                    rr_ptr_d     = (irq_id == IDX_W'(N - 1)) ? '0 : irq_id + 1'b1;
                    state_d      = SERVICE;
                end else if (!cur_eligible_c) begin
                    irq_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    in_service_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                irq_req_d    = 1'b0;
                in_service_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // A fresh edge beats a same-cycle ack clear.
    assign pending_d = (edge_mode & (edge_set_c | (pending & ~clr_c))) | (~edge_mode & irq_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            irq_req    <= 1'b0;
            irq_id     <= '0;
            in_service <= 1'b0;
            pending    <= '0;
            irq_in_q   <= '0;
            rr_ptr     <= '0;
        end else begin
            state      <= state_d;
            irq_req    <= irq_req_d;
            irq_id     <= irq_id_d;
            in_service <= in_service_d;
            pending    <= pending_d;
            irq_in_q   <= irq_in;
            rr_ptr     <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed bench for irq_prio_ctrl: fixed priority (N=8), round-robin (N=4) and N=32 instances.
module tb_irq_prio_ctrl;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    logic [7:0]  a_irq, a_edge, a_mask, a_pend;
    logic        a_ack, a_eoi, a_req, a_svc;
    logic [2:0]  a_id;
    logic [3:0]  b_irq, b_edge, b_mask, b_pend;
    logic        b_ack, b_eoi, b_req, b_svc;
    logic [1:0]  b_id;
    logic [31:0] c_irq, c_edge, c_mask, c_pend;
    logic        c_ack, c_eoi, c_req, c_svc;
    logic [4:0]  c_id;

    logic [1:0] rr_exp [4] = '{2'd0, 2'd3, 2'd0, 2'd3};

    irq_prio_ctrl #(.N(8), .IDX_W(3), .ROUND_ROBIN(0)) dut_a (
        .clk(clk), .reset(reset), .irq_in(a_irq), .edge_mode(a_edge), .mask(a_mask),
        .ack(a_ack), .eoi(a_eoi), .irq_req(a_req), .irq_id(a_id), .in_service(a_svc),
        .pending(a_pend));

    irq_prio_ctrl #(.N(4), .IDX_W(2), .ROUND_ROBIN(1)) dut_b (
        .clk(clk), .reset(reset), .irq_in(b_irq), .edge_mode(b_edge), .mask(b_mask),
        .ack(b_ack), .eoi(b_eoi), .irq_req(b_req), .irq_id(b_id), .in_service(b_svc),
        .pending(b_pend));

    irq_prio_ctrl #(.N(32), .IDX_W(5), .ROUND_ROBIN(1)) dut_c (
        .clk(clk), .reset(reset), .irq_in(c_irq), .edge_mode(c_edge), .mask(c_mask),
        .ack(c_ack), .eoi(c_eoi), .irq_req(c_req), .irq_id(c_id), .in_service(c_svc),
        .pending(c_pend));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_irq = '0; a_edge = 8'hFF; a_mask = '0; a_ack = 1'b0; a_eoi = 1'b0;
        b_irq = '0; b_edge = '0;    b_mask = '0; b_ack = 1'b0; b_eoi = 1'b0;
        c_irq = '0; c_edge = '1;    c_mask = '0; c_ack = 1'b0; c_eoi = 1'b0;
        step(); step();
        vectors++;
        if ({a_req, a_id, a_svc, a_pend} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_a: got req=%b id=%0d svc=%b pend=%h, want all 0", a_req, a_id, a_svc, a_pend);
        end
        vectors++;
        if ({b_req, b_svc, b_pend, c_req, c_svc, c_pend} !== 40'd0) begin
            miscompares++;
            $display("FAIL reset_bc: got b_req=%b b_pend=%h c_req=%b c_pend=%h, want 0", b_req, b_pend, c_req, c_pend);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_fixed_priority();
        a_irq = 8'h24; step(); a_irq = '0;
        vectors++;
        if (a_pend !== 8'h24 || a_req !== 1'b0) begin
            miscompares++;
            $display("FAIL fixed_pend: got pend=%h req=%b, want 24 0", a_pend, a_req);
        end
        step();
        vectors++;
        if (a_req !== 1'b1 || a_id !== 3'd2) begin
            miscompares++;
            $display("FAIL fixed_first: got req=%b id=%0d, want 1 2", a_req, a_id);
        end
        a_ack = 1'b1; step(); a_ack = 1'b0;
        vectors++;
        if (a_req !== 1'b0 || a_svc !== 1'b1 || a_pend !== 8'h20) begin
            miscompares++;
            $display("FAIL fixed_ack: got req=%b svc=%b pend=%h, want 0 1 20", a_req, a_svc, a_pend);
        end
        a_eoi = 1'b1; step(); a_eoi = 1'b0;
        vectors++;
        if (a_req !== 1'b0 || a_svc !== 1'b0) begin
            miscompares++;
            $display("FAIL fixed_eoi_gap: got req=%b svc=%b, want 0 0", a_req, a_svc);
        end
        step();
        vectors++;
        if (a_req !== 1'b1 || a_id !== 3'd5) begin
            miscompares++;
            $display("FAIL fixed_second: got req=%b id=%0d, want 1 5", a_req, a_id);
        end
        a_ack = 1'b1; step(); a_ack = 1'b0;
        vectors++;
        if (a_pend !== 8'h00 || a_svc !== 1'b1) begin
            miscompares++;
            $display("FAIL fixed_drain: got pend=%h svc=%b, want 00 1", a_pend, a_svc);
        end
        a_eoi = 1'b1; step(); a_eoi = 1'b0;
        vectors++;
        if (a_svc !== 1'b0) begin
            miscompares++;
            $display("FAIL fixed_end: got svc=%b, want 0", a_svc);
        end
    endtask

    task automatic test_ignored_handshake();
        a_ack = 1'b1; step(); a_ack = 1'b0;
        vectors++;
        if (a_req !== 1'b0 || a_svc !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_in_idle: got req=%b svc=%b, want 0 0", a_req, a_svc);
        end
        a_irq = 8'h08; step(); a_irq = '0; step();
        vectors++;
        if (a_req !== 1'b1 || a_id !== 3'd3) begin
            miscompares++;
            $display("FAIL src3_req: got req=%b id=%0d, want 1 3", a_req, a_id);
        end
        a_eoi = 1'b1; step(); a_eoi = 1'b0;
        vectors++;
        if (a_req !== 1'b1 || a_svc !== 1'b0 || a_id !== 3'd3) begin
            miscompares++;
            $display("FAIL eoi_in_req: got req=%b svc=%b id=%0d, want 1 0 3", a_req, a_svc, a_id);
        end
        a_ack = 1'b1; step(); a_ack = 1'b0;
        a_eoi = 1'b1; step(); a_eoi = 1'b0;
        vectors++;
        if (a_svc !== 1'b0 || a_pend !== 8'h00) begin
            miscompares++;
            $display("FAIL src3_done: got svc=%b pend=%h, want 0 00", a_svc, a_pend);
        end
    endtask

    task automatic test_coincide_edge();
        a_irq = 8'h02; step(); a_irq = '0; step();
        vectors++;
        if (a_req !== 1'b1 || a_id !== 3'd1) begin
            miscompares++;
            $display("FAIL src1_req: got req=%b id=%0d, want 1 1", a_req, a_id);
        end
        a_irq = 8'h02; a_ack = 1'b1; step(); a_ack = 1'b0; a_irq = '0;
        vectors++;
        if (a_pend !== 8'h02 || a_svc !== 1'b1) begin
            miscompares++;
            $display("FAIL set_beats_clear: got pend=%h svc=%b, want 02 1", a_pend, a_svc);
        end
        a_eoi = 1'b1; step(); a_eoi = 1'b0; step();
        vectors++;
        if (a_req !== 1'b1 || a_id !== 3'd1) begin
            miscompares++;
            $display("FAIL src1_again: got req=%b id=%0d, want 1 1", a_req, a_id);
        end
        a_ack = 1'b1; step(); a_ack = 1'b0;
        a_eoi = 1'b1; step(); a_eoi = 1'b0;
        vectors++;
        if (a_pend !== 8'h00) begin
            miscompares++;
            $display("FAIL src1_clear: got pend=%h, want 00", a_pend);
        end
    endtask

    task automatic test_retract();
        a_edge = 8'hEF; a_irq = 8'h10; step(); step();
        vectors++;
        if (a_req !== 1'b1 || a_id !== 3'd4) begin
            miscompares++;
            $display("FAIL lvl4_req: got req=%b id=%0d, want 1 4", a_req, a_id);
        end
        a_mask = 8'h10; step();
        vectors++;
        if (a_req !== 1'b0 || a_id !== 3'd4) begin
            miscompares++;
            $display("FAIL retract: got req=%b id=%0d, want 0 4", a_req, a_id);
        end
        step();
        vectors++;
        if (a_req !== 1'b0 || a_svc !== 1'b0) begin
            miscompares++;
            $display("FAIL masked_idle: got req=%b svc=%b, want 0 0", a_req, a_svc);
        end
        a_mask = '0; step();
        vectors++;
        if (a_req !== 1'b1 || a_id !== 3'd4) begin
            miscompares++;
            $display("FAIL unmask_req: got req=%b id=%0d, want 1 4", a_req, a_id);
        end
        a_mask = 8'h10; a_ack = 1'b1; step(); a_ack = 1'b0;
        vectors++;
        if (a_svc !== 1'b1 || a_req !== 1'b0 || a_pend !== 8'h10) begin
            miscompares++;
            $display("FAIL ack_wins: got svc=%b req=%b pend=%h, want 1 0 10", a_svc, a_req, a_pend);
        end
        a_mask = '0; a_irq = '0; a_eoi = 1'b1; step(); a_eoi = 1'b0; step();
        vectors++;
        if (a_req !== 1'b0 || a_pend !== 8'h00) begin
            miscompares++;
            $display("FAIL lvl4_drop: got req=%b pend=%h, want 0 00", a_req, a_pend);
        end
        a_edge = 8'hFF;
    endtask

    task automatic test_reset_mid_service();
        a_edge = 8'h00; a_irq = 8'hF0; step(); step();
        a_ack = 1'b1; step(); a_ack = 1'b0;
        vectors++;
        if (a_svc !== 1'b1 || a_pend !== 8'hF0 || a_id !== 3'd4) begin
            miscompares++;
            $display("FAIL pre_reset: got svc=%b pend=%h id=%0d, want 1 F0 4", a_svc, a_pend, a_id);
        end
        reset = 1'b1; step(); reset = 1'b0;
        vectors++;
        if ({a_req, a_id, a_svc, a_pend} !== 13'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got req=%b id=%0d svc=%b pend=%h, want all 0", a_req, a_id, a_svc, a_pend);
        end
        step();
        vectors++;
        if (a_req !== 1'b0 || a_pend !== 8'hF0) begin
            miscompares++;
            $display("FAIL post_reset1: got req=%b pend=%h, want 0 F0", a_req, a_pend);
        end
        step();
        vectors++;
        if (a_req !== 1'b1 || a_id !== 3'd4) begin
            miscompares++;
            $display("FAIL post_reset2: got req=%b id=%0d, want 1 4", a_req, a_id);
        end
        a_irq = '0; a_ack = 1'b1; step(); a_ack = 1'b0;
        a_eoi = 1'b1; step(); a_eoi = 1'b0; a_edge = 8'hFF; step();
    endtask

    task automatic test_round_robin();
        b_edge = 4'h0; b_irq = 4'b1001; step();
        for (int r = 0; r < 4; r++) begin
            step();
            vectors++;
            if (b_req !== 1'b1 || b_id !== rr_exp[r]) begin
                miscompares++;
                $display("FAIL rr_round%0d: got req=%b id=%0d, want 1 %0d", r, b_req, b_id, rr_exp[r]);
            end
            b_ack = 1'b1; step(); b_ack = 1'b0;
            if (r == 2) b_irq = 4'b1000;
            if (r == 3) b_irq = 4'b1001;
            b_eoi = 1'b1; step(); b_eoi = 1'b0;
        end
        step();
        vectors++;
        if (b_req !== 1'b1 || b_id !== 2'd0) begin
            miscompares++;
            $display("FAIL rr_wrap: got req=%b id=%0d, want 1 0", b_req, b_id);
        end
        b_irq = '0; b_ack = 1'b1; step(); b_ack = 1'b0;
        b_eoi = 1'b1; step(); b_eoi = 1'b0;
    endtask

    task automatic test_src31();
        c_irq = 32'h8000_0000; step(); c_irq = '0; step();
        vectors++;
        if (c_req !== 1'b1 || c_id !== 5'd31) begin
            miscompares++;
            $display("FAIL src31_req: got req=%b id=%0d, want 1 31", c_req, c_id);
        end
        c_ack = 1'b1; step(); c_ack = 1'b0;
        vectors++;
        if (c_svc !== 1'b1 || c_pend !== 32'h0) begin
            miscompares++;
            $display("FAIL src31_ack: got svc=%b pend=%h, want 1 0", c_svc, c_pend);
        end
        c_eoi = 1'b1; step(); c_eoi = 1'b0;
        c_irq = 32'h8000_0020; step(); c_irq = '0; step();
        vectors++;
        if (c_req !== 1'b1 || c_id !== 5'd5) begin
            miscompares++;
            $display("FAIL src31_wrap: got req=%b id=%0d, want 1 5", c_req, c_id);
        end
        c_ack = 1'b1; step(); c_ack = 1'b0;
        c_eoi = 1'b1; step(); c_eoi = 1'b0; step();
        vectors++;
        if (c_req !== 1'b1 || c_id !== 5'd31) begin
            miscompares++;
            $display("FAIL src31_next: got req=%b id=%0d, want 1 31", c_req, c_id);
        end
        c_ack = 1'b1; step(); c_ack = 1'b0;
        c_eoi = 1'b1; step(); c_eoi = 1'b0;
        vectors++;
        if (c_pend !== 32'h0 || c_svc !== 1'b0) begin
            miscompares++;
            $display("FAIL src31_done: got pend=%h svc=%b, want 0 0", c_pend, c_svc);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_fixed_priority();
        test_ignored_handshake();
        test_coincide_edge();
        test_retract();
        test_reset_mid_service();
        test_round_robin();
        test_src31();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
